// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter: register address and
// the buffered multi-cycle result entry.
package regfile_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int REGS       = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef struct packed {
        reg_addr_t       rd;
        logic [XLEN-1:0] data;
        logic            live;
    } wb_entry_t;
endpackage

// File: rtl/regfile_wb_arbiter_fifo.sv
// Circular buffer of multi-cycle results. Every entry can be killed by a
// younger pipeline write to the same register.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  wb_entry_t                  push_entry_i,
    input  logic                       pop_i,
    input  logic                       kill_en_i,
    input  reg_addr_t                  kill_rd_i,
    output wb_entry_t                  head_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [DEPTH-1:0]           live_o,
    output reg_addr_t                  rd_o [DEPTH]
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    reg_addr_t         rd_q   [DEPTH];
    logic [XLEN-1:0]   data_q [DEPTH];
    logic [DEPTH-1:0]  live_q, live_d;
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q, count_d;

    // Push wins over kill on the written slot: a same-cycle enqueue stays live.
    always_comb begin
        live_d = live_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (kill_en_i && live_q[i] && (rd_q[i] == kill_rd_i)) live_d[i] = 1'b0;
            if (pop_i && (rd_ptr_q == PW'(i)))                    live_d[i] = 1'b0;
            if (push_i && (wr_ptr_q == PW'(i)))                   live_d[i] = 1'b1;
        end
        count_d = count_q + CW'(push_i) - CW'(pop_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            live_q  <= live_d;
            count_q <= count_d;
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            rd_q[wr_ptr_q]   <= push_entry_i.rd;
            data_q[wr_ptr_q] <= push_entry_i.data;
        end
    end

    always_comb begin
        head_o.rd   = rd_q[rd_ptr_q];
        head_o.data = data_q[rd_ptr_q];
        head_o.live = live_q[rd_ptr_q];
        for (int i = 0; i < DEPTH; i++) rd_o[i] = rd_q[i];
    end

    assign live_o  = live_q;
    assign count_o = count_q;
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges pipeline writeback (priority) and buffered multi-cycle results onto
// the single register-file write port, and exports the pending-write mask.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32,
    parameter int REGS  = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wb_valid,
    input  logic [4:0]             wb_rd,
    input  logic [XLEN-1:0]        wb_data,
    input  logic                   mdu_valid,
    output logic                   mdu_ready,
    input  logic [4:0]             mdu_rd,
    input  logic [XLEN-1:0]        mdu_data,
    output logic                   w_en,
    output logic [4:0]             w_adr,
    output logic [XLEN-1:0]        w_data,
    output logic [REGS-1:0]        pending,
    output logic [$clog2(DEPTH):0] count
);
    wb_entry_t        push_entry, head;
    logic             wb_hit, push, pop, full, empty;
    logic [DEPTH-1:0] live;
    reg_addr_t        ent_rd [DEPTH];

    logic             w_en_q, w_en_d;
    logic [4:0]       w_adr_q, w_adr_d;
    logic [XLEN-1:0]  w_data_q, w_data_d;

    assign wb_hit    = wb_valid && (wb_rd != '0);
    assign mdu_ready = !full;
    // x0 results complete the handshake but are never stored.
    assign push      = mdu_valid && !full && (mdu_rd != '0);
    assign pop       = !wb_hit && !empty;

    always_comb begin
        push_entry.rd   = mdu_rd;
        push_entry.data = mdu_data;
        push_entry.live = 1'b1;
    end

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .kill_en_i    (wb_hit),
        .kill_rd_i    (wb_rd),
        .head_o       (head),
        .count_o      (count),
        .full_o       (full),
        .empty_o      (empty),
        .live_o       (live),
        .rd_o         (ent_rd)
    );

    // A killed head still pops, costing one idle write cycle.
    always_comb begin
        w_en_d   = 1'b0;
        w_adr_d  = w_adr_q;
        w_data_d = w_data_q;
        if (wb_hit) begin
            w_en_d   = 1'b1;
            w_adr_d  = wb_rd;
            w_data_d = wb_data;
        end else if (pop && head.live) begin
            w_en_d   = 1'b1;
            w_adr_d  = head.rd;
            w_data_d = head.data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_en_q   <= 1'b0;
            w_adr_q  <= '0;
            w_data_q <= '0;
        end else begin
            w_en_q   <= w_en_d;
            w_adr_q  <= w_adr_d;
            w_data_q <= w_data_d;
        end
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live[i]) pending[ent_rd[i]] = 1'b1;
        end
        pending[0] = 1'b0;
    end

    assign w_en   = w_en_q;
    assign w_adr  = w_adr_q;
    assign w_data = w_data_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter against a queue-based
// reference model of the write-port arbitration rules.
module tb_regfile_wb_arbiter;
    localparam int DEPTH = 4;
    localparam int XLEN  = 32;
    localparam int REGS  = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            wb_valid = 1'b0;
    logic [4:0]      wb_rd = '0;
    logic [XLEN-1:0] wb_data = '0;
    logic            mdu_valid = 1'b0;
    logic            mdu_ready;
    logic [4:0]      mdu_rd = '0;
    logic [XLEN-1:0] mdu_data = '0;
    logic            w_en;
    logic [4:0]      w_adr;
    logic [XLEN-1:0] w_data;
    logic [REGS-1:0] pending;
    logic [CW-1:0]   count;

    regfile_wb_arbiter #(.DEPTH(DEPTH), .XLEN(XLEN), .REGS(REGS)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
        .w_en(w_en), .w_adr(w_adr), .w_data(w_data),
        .pending(pending), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
        bit              live;
    } ment_t;

    ment_t           mq[$];
    logic            m_en;
    logic [4:0]      m_adr;
    logic [XLEN-1:0] m_data;
    bit              last_acc;
    int              total = 0;
    int              bad = 0;
    logic [4:0]      wr_log[$];

    function automatic logic [REGS-1:0] m_pending();
        logic [REGS-1:0] p = '0;
        foreach (mq[i]) if (mq[i].live && mq[i].rd != 0) p[mq[i].rd] = 1'b1;
        return p;
    endfunction

    function automatic logic [73:0] m_state();
        return {m_en, m_adr, m_data, m_pending(), CW'(mq.size()), mq.size() < DEPTH};
    endfunction

    function automatic logic [73:0] dut_state();
        return {w_en, w_adr, w_data, pending, count, mdu_ready};
    endfunction

    // Model of one clock edge using the inputs currently applied.
    task automatic model_step();
        bit    ready;
        ment_t e;
        ready    = mq.size() < DEPTH;
        last_acc = mdu_valid && ready;
        if (!rst_n) begin
            mq.delete();
            m_en = 0; m_adr = '0; m_data = '0;
            return;
        end
        if (wb_valid && wb_rd != 0) begin
            m_en = 1; m_adr = wb_rd; m_data = wb_data;
            foreach (mq[i]) if (mq[i].rd == wb_rd) mq[i].live = 0;
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            m_en = e.live;
            if (e.live) begin m_adr = e.rd; m_data = e.data; end
        end else begin
            m_en = 0;
        end
        if (last_acc && mdu_rd != 0) mq.push_back('{mdu_rd, mdu_data, 1'b1});
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        if (w_en) wr_log.push_back(w_adr);
    endtask

    task automatic test_reset();
        rst_n = 0;
        model_step();
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({w_en, w_adr, w_data, pending, count, mdu_ready} !== {1'b0, 5'd0, 32'd0, 32'd0, 3'd0, 1'b1}) begin
                bad++;
                $display("FAIL reset_state got=%h want=%h", dut_state(), {1'b0, 5'd0, 32'd0, 32'd0, 3'd0, 1'b1});
            end
        end
        rst_n = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if ({w_en, pending, count, mdu_ready} !== {1'b0, 32'd0, 3'd0, 1'b1}) begin
                bad++;
                $display("FAIL idle_after_reset got=%h want=%h", {w_en, pending, count, mdu_ready}, {1'b0, 32'd0, 3'd0, 1'b1});
            end
        end
    endtask

    task automatic test_pipeline();
        wb_valid = 1; wb_rd = 5; wb_data = 32'hDEADBEEF;
        tick();
        total++;
        if ({w_en, w_adr, w_data} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
            bad++;
            $display("FAIL pipe_write got=%h want=%h", {w_en, w_adr, w_data}, {1'b1, 5'd5, 32'hDEADBEEF});
        end
        wb_rd = 0; wb_data = 32'h12345678;
        tick();
        total++;
        if (w_en !== 1'b0 || w_data !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL pipe_x0 got en=%b data=%h want en=0 data=deadbeef", w_en, w_data);
        end
        wb_valid = 0;
    endtask

    task automatic test_drain();
        mdu_valid = 1; mdu_rd = 7; mdu_data = 32'h11;
        tick();
        total++;
        if (pending[7] !== 1'b1 || count !== 3'd1 || w_en !== 1'b0) begin
            bad++;
            $display("FAIL drain_enq got pend7=%b count=%0d en=%b want 1 1 0", pending[7], count, w_en);
        end
        mdu_rd = 9; mdu_data = 32'h22;
        tick();
        mdu_valid = 0;
        total++;
        if ({w_en, w_adr, w_data, pending[9]} !== {1'b1, 5'd7, 32'h11, 1'b1}) begin
            bad++;
            $display("FAIL drain_first got=%h want=%h", {w_en, w_adr, w_data, pending[9]}, {1'b1, 5'd7, 32'h11, 1'b1});
        end
        tick();
        total++;
        if ({w_en, w_adr, w_data, pending, count} !== {1'b1, 5'd9, 32'h22, 32'd0, 3'd0}) begin
            bad++;
            $display("FAIL drain_second got=%h want=%h", {w_en, w_adr, w_data, pending, count}, {1'b1, 5'd9, 32'h22, 32'd0, 3'd0});
        end
        tick();
    endtask

    task automatic test_priority();
        logic [4:0] rds [4];
        rds = '{5'd1, 5'd2, 5'd4, 5'd6};
        mdu_valid = 1; mdu_rd = 3; mdu_data = 32'h33;
        for (int i = 0; i < 4; i++) begin
            wb_valid = 1; wb_rd = rds[i]; wb_data = 32'h100 + i;
            tick();
            mdu_valid = 0;
            total++;
            if ({w_en, w_adr, w_data, count} !== {1'b1, rds[i], 32'h100 + i, 3'd1}) begin
                bad++;
                $display("FAIL prio_pipe%0d got=%h want=%h", i, {w_en, w_adr, w_data, count}, {1'b1, rds[i], 32'h100 + i, 3'd1});
            end
        end
        wb_valid = 0;
        tick();
        total++;
        if ({w_en, w_adr, w_data, count} !== {1'b1, 5'd3, 32'h33, 3'd0}) begin
            bad++;
            $display("FAIL prio_fifo got=%h want=%h", {w_en, w_adr, w_data, count}, {1'b1, 5'd3, 32'h33, 3'd0});
        end
    endtask

    task automatic test_kill();
        mdu_valid = 1; mdu_rd = 10; mdu_data = 32'hAA;
        wb_valid = 1; wb_rd = 1; wb_data = 32'h1;
        tick();
        mdu_valid = 0;
        wb_rd = 10; wb_data = 32'hBB;
        tick();
        total++;
        if ({w_en, w_adr, w_data, pending[10], count} !== {1'b1, 5'd10, 32'hBB, 1'b0, 3'd1}) begin
            bad++;
            $display("FAIL kill_pipe got=%h want=%h", {w_en, w_adr, w_data, pending[10], count}, {1'b1, 5'd10, 32'hBB, 1'b0, 3'd1});
        end
        wb_valid = 0;
        tick();
        total++;
        if ({w_en, w_data, count} !== {1'b0, 32'hBB, 3'd0}) begin
            bad++;
            $display("FAIL kill_pop got=%h want=%h", {w_en, w_data, count}, {1'b0, 32'hBB, 3'd0});
        end
    endtask

    task automatic test_full();
        logic [4:0] exp_rd [5];
        int guard;
        exp_rd = '{5'd11, 5'd12, 5'd13, 5'd14, 5'd15};
        wb_valid = 1;
        for (int i = 0; i < 4; i++) begin
            wb_rd = 5'd20 + 5'(i); wb_data = i;
            mdu_valid = 1; mdu_rd = exp_rd[i]; mdu_data = 32'h500 + i;
            tick();
        end
        mdu_rd = exp_rd[4]; mdu_data = 32'h504;
        wb_rd = 5'd25;
        tick();
        total++;
        if ({mdu_ready, count} !== {1'b0, 3'd4} || last_acc) begin
            bad++;
            $display("FAIL full_ready got ready=%b count=%0d want 0 4", mdu_ready, count);
        end
        wb_valid = 0;
        wr_log.delete();
        guard = 0;
        while (mdu_valid && guard < 20) begin
            tick();
            if (last_acc) mdu_valid = 0;
            guard++;
        end
        for (int i = 0; i < 8; i++) tick();
        total++;
        if (wr_log.size() != 5) begin
            bad++;
            $display("FAIL full_drain_count got=%0d want=5", wr_log.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                total++;
                if (wr_log[i] !== exp_rd[i]) begin
                    bad++;
                    $display("FAIL full_order%0d got=%0d want=%0d", i, wr_log[i], exp_rd[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            wb_valid = ($urandom_range(0, 99) < 45);
            wb_rd    = 5'($urandom_range(0, 7));
            wb_data  = $urandom;
            if (!mdu_valid || last_acc) begin
                mdu_valid = ($urandom_range(0, 99) < 50);
                mdu_rd    = 5'($urandom_range(0, 7));
                mdu_data  = $urandom;
            end
            tick();
            total++;
            if (dut_state() !== m_state()) begin
                bad++;
                $display("FAIL random_c%0d got=%h want=%h", c, dut_state(), m_state());
            end
        end
        wb_valid = 0; mdu_valid = 0;
        for (int i = 0; i < 6; i++) tick();
        total++;
        if (dut_state() !== m_state()) begin
            bad++;
            $display("FAIL random_drain got=%h want=%h", dut_state(), m_state());
        end
    endtask

    task automatic test_midreset();
        wb_valid = 1; wb_rd = 2; wb_data = 32'h77;
        mdu_valid = 1;
        for (int i = 0; i < 3; i++) begin
            mdu_rd = 5'd16 + 5'(i); mdu_data = i;
            tick();
        end
        mdu_valid = 0; wb_valid = 0;
        #2 rst_n = 0;
        #1;
        model_step();
        total++;
        if (dut_state() !== {1'b0, 5'd0, 32'd0, 32'd0, 3'd0, 1'b1}) begin
            bad++;
            $display("FAIL midreset got=%h want=%h", dut_state(), {1'b0, 5'd0, 32'd0, 32'd0, 3'd0, 1'b1});
        end
        tick();
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (w_en !== 1'b0 || count !== 3'd0) begin
                bad++;
                $display("FAIL midreset_idle got en=%b count=%0d want 0 0", w_en, count);
            end
        end
    endtask

    initial begin
        m_en = 0; m_adr = '0; m_data = '0; last_acc = 0;
        test_reset();
        test_pipeline();
        test_drain();
        test_priority();
        test_kill();
        test_full();
        test_random();
        test_midreset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
